lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
Leaky integrate-and-fire neuron. It is the receiving end of the synapse path: it consumes 8-bit weighted values delivered by a synapse, accumulates them into a membrane potential with per-cycle leak, and emits a one-cycle spike when the potential reaches threshold. After each spike it enforces a refractory period during which it accepts no input.

Parameters:
MEM_W, 12, membrane potential width in bits; legal range 8..16.
THRESHOLD, 512, firing threshold, unsigned, MEM_W bits; legal range 1..2^MEM_W-1.
LEAK_SHIFT, 3, leak per cycle is membrane >> LEAK_SHIFT; legal range 1..MEM_W-1.
REFRACT_CYCLES, 4, refractory cycles after the fire cycle; legal range 0..255.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
valid_i  input  1  data_i carries a weighted synaptic value this cycle.
data_i  input  8  unsigned weighted value from the synapse.
ready_o  output  1  neuron accepts input this cycle.
spike_o  output  1  registered one-cycle spike pulse.
membrane_o  output  MEM_W  current membrane potential register.
spike_count_o  output  8  count of spikes emitted, wraps modulo 256.

Behaviour:
- Clock and reset:
  - Single clock domain, clk_i.
  - rst_ni low asynchronously forces state=INTEGRATE, membrane=0, spike_o=0, spike_count_o=0, refractory counter=0. This holds at any time, including mid-FIRE or mid-REFRACT.
  - ready_o=1 while in reset and after release.
- States: INTEGRATE, FIRE, REFRACT.
- ready_o is combinational from state: 1 only in INTEGRATE.
- An input is accepted when valid_i && ready_o. Inputs presented while ready_o=0 are dropped, with no effect on any state.
- INTEGRATE, every cycle:
  - leaked = mem - (mem >> LEAK_SHIFT).
  - sum = leaked + (accepted ? data_i : 0), computed at MEM_W+1 bits.
  - next = min(sum, 2^MEM_W-1), i.e. saturating and never wrapping.
  - If next >= THRESHOLD: mem <= 0, state <= FIRE, spike_count <= spike_count+1 (wraps 255->0).
  - Otherwise mem <= next and the state stays INTEGRATE.
  - Leak applies even when valid_i=0. With mem=0 and no input, mem stays 0.
- FIRE: lasts exactly 1 cycle.
  - spike_o=1 and mem=0.
  - Next state is REFRACT with counter loaded to REFRACT_CYCLES-1, or INTEGRATE if REFRACT_CYCLES=0.
- REFRACT: mem held at 0 and spike_o=0.
  - Counter decrements each cycle; at counter==0 the next state is INTEGRATE.
- Timing:
  - spike_o goes high the cycle after the accepting edge that crossed threshold. Latency from the crossing input to spike_o is 1 cycle.
  - ready_o is low for 1+REFRACT_CYCLES consecutive cycles per spike.
- membrane_o equals the mem register, updated on the same edge as state.
- Threshold compare uses the saturated value, so THRESHOLD=2^MEM_W-1 is reachable through saturation.
- An input that crosses threshold is consumed. No residual carries over; mem restarts at 0.
- spike_o is never high for two consecutive cycles.

Test Plan:
1. Reset with defaults: hold rst_ni=0 mid-run, then release -> membrane_o=0, spike_o=0, spike_count_o=0, ready_o=1 immediately on assertion, with no clock edge needed.
2. Leak decay: one accepted data_i=100, then valid_i=0 -> membrane_o sequence 100, 88, 77, 68, 60; no spike.
3. Fire: data_i=255 accepted on 3 consecutive cycles -> membrane_o 255, then 479, then threshold crossed (675 >= 512). Next cycle: spike_o=1 for one cycle, membrane_o=0, spike_count_o=1, ready_o=0 for exactly 5 cycles, then 1.
4. Refractory drop: hold valid_i=1, data_i=255 throughout scenario 3 -> membrane_o stays 0 during FIRE/REFRACT; integration resumes with 255 on the first ready cycle; second spike follows 3 accepted inputs later.
5. Saturation with MEM_W=8, THRESHOLD=255, LEAK_SHIFT=7, REFRACT_CYCLES=0:
   - data_i=200 twice -> 200, then 199+200 saturates to 255 and fires.
   - spike_o pulses; ready_o is low for exactly 1 cycle.
6. Async reset during REFRACT (counter=2), plus counter wrap:
   - Reset during REFRACT -> state returns to INTEGRATE and ready_o=1 asynchronously; spike_count_o=0.
   - Separately, 256 spikes -> spike_count_o wraps to 0.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: accumulates 8-bit weighted synaptic values with
// per-cycle leak, fires a one-cycle spike at threshold, then stays refractory.
module lif_neuron #(
    parameter int MEM_W          = 12,
    parameter int THRESHOLD      = 512,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [7:0]       data_i,
    output logic             ready_o,
    output logic             spike_o,
    output logic [MEM_W-1:0] membrane_o,
    output logic [7:0]       spike_count_o
);

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } state_t;

    localparam logic [MEM_W-1:0] THRESH_C       = MEM_W'(THRESHOLD);
    localparam bit               NO_REFRACT_C   = (REFRACT_CYCLES == 0);
    localparam logic [7:0]       REFRACT_LOAD_C = NO_REFRACT_C ? 8'd0 : 8'(REFRACT_CYCLES - 1);

    state_t           state_r;
    logic [MEM_W-1:0] mem_r;
    logic             spike_r;
    logic [7:0]       count_r;
    logic [7:0]       refract_r;

    logic             accept_s;
    logic [MEM_W-1:0] leaked_s;
    logic [MEM_W-1:0] add_s;
    logic [MEM_W:0]   sum_s;
    logic [MEM_W-1:0] next_mem_s;
    logic             cross_s;

    // Leak, integrate and saturate; the threshold test sees the clamped value.
    always_comb begin
        accept_s = valid_i && (state_r == ST_INTEGRATE);
        leaked_s = mem_r - (mem_r >> LEAK_SHIFT);
        if (accept_s) begin
            add_s = MEM_W'(data_i);
        end else begin
            add_s = {MEM_W{1'b0}};
        end
        sum_s = {1'b0, leaked_s} + {1'b0, add_s};
        if (sum_s[MEM_W]) begin
            next_mem_s = {MEM_W{1'b1}};
        end else begin
            next_mem_s = sum_s[MEM_W-1:0];
        end
        cross_s = (next_mem_s >= THRESH_C);
    end

    // Neuron state machine with membrane, spike and spike counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_INTEGRATE;
            mem_r     <= {MEM_W{1'b0}};
            spike_r   <= 1'b0;
            count_r   <= 8'd0;
            refract_r <= 8'd0;
        end else begin
            case (state_r)
                ST_INTEGRATE: begin
                    if (cross_s) begin
                        // The crossing input is consumed; no residual carries over.
                        state_r <= ST_FIRE;
                        mem_r   <= {MEM_W{1'b0}};
                        spike_r <= 1'b1;
                        count_r <= count_r + 8'd1;
                    end else begin
                        mem_r   <= next_mem_s;
                        spike_r <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    mem_r   <= {MEM_W{1'b0}};
                    spike_r <= 1'b0;
                    if (NO_REFRACT_C) begin
                        state_r <= ST_INTEGRATE;
                    end else begin
                        state_r   <= ST_REFRACT;
                        refract_r <= REFRACT_LOAD_C;
                    end
                end
                ST_REFRACT: begin
                    mem_r   <= {MEM_W{1'b0}};
                    spike_r <= 1'b0;
                    if (refract_r == 8'd0) begin
                        state_r <= ST_INTEGRATE;
                    end else begin
                        refract_r <= refract_r - 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_INTEGRATE;
                    mem_r     <= {MEM_W{1'b0}};
                    spike_r   <= 1'b0;
                    refract_r <= 8'd0;
                end
            endcase
        end
    end

    assign ready_o       = (state_r == ST_INTEGRATE);
    assign spike_o       = spike_r;
    assign membrane_o    = mem_r;
    assign spike_count_o = count_r;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron: default instance plus a small
// saturating instance (MEM_W=8, THRESHOLD=255, LEAK_SHIFT=7, REFRACT_CYCLES=0).
module tb_lif_neuron;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        spike;
    logic [11:0] membrane;
    logic [7:0]  count;

    logic        rst_s_n;
    logic        valid_s;
    logic [7:0]  data_s;
    logic        ready_s;
    logic        spike_s;
    logic [7:0]  membrane_s;
    logic [7:0]  count_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-edge trace with valid=1, data=255 held (fire, refractory, refire).
    int exp_mem_t   [11] = '{255, 479, 0, 0, 0, 0, 0, 0, 255, 479, 0};
    int exp_spike_t [11] = '{0,   0,   1, 0, 0, 0, 0, 0, 0,   0,   1};
    int exp_ready_t [11] = '{1,   1,   0, 0, 0, 0, 0, 1, 1,   1,   0};
    int exp_leak_t  [5]  = '{100, 88, 77, 68, 60};

    lif_neuron dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid),
        .data_i        (data),
        .ready_o       (ready),
        .spike_o       (spike),
        .membrane_o    (membrane),
        .spike_count_o (count)
    );

    lif_neuron #(
        .MEM_W          (8),
        .THRESHOLD      (255),
        .LEAK_SHIFT     (7),
        .REFRACT_CYCLES (0)
    ) dut_sat (
        .clk_i         (clk),
        .rst_ni        (rst_s_n),
        .valid_i       (valid_s),
        .data_i        (data_s),
        .ready_o       (ready_s),
        .spike_o       (spike_s),
        .membrane_o    (membrane_s),
        .spike_count_o (count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        data  = 8'd0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Outputs while reset is held from time zero.
        n_cmp++; if (membrane !== 12'd0) begin n_bad++; $display("FAIL reset_mem got %0d want 0", membrane); end
        n_cmp++; if (spike !== 1'b0) begin n_bad++; $display("FAIL reset_spike got %0b want 0", spike); end
        n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", ready); end
        cyc();
        rst_n = 1'b1;
        valid = 1'b1;
        data  = 8'd50;
        cyc();
        valid = 1'b0;
        n_cmp++; if (membrane !== 12'd50) begin n_bad++; $display("FAIL pre_reset_mem got %0d want 50", membrane); end
        // Assert reset between edges: must take effect without a clock.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (membrane !== 12'd0) begin n_bad++; $display("FAIL async_reset_mem got %0d want 0", membrane); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_ready got %0b want 1", ready); end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_leak();
        do_reset();
        valid = 1'b1;
        data  = 8'd100;
        for (int i = 0; i < 5; i++) begin
            cyc();
            valid = 1'b0;
            n_cmp++;
            if (membrane !== 12'(exp_leak_t[i]) || spike !== 1'b0) begin
                n_bad++;
                $display("FAIL leak_step%0d got mem=%0d spike=%0b want mem=%0d spike=0", i, membrane, spike, exp_leak_t[i]);
            end
        end
    endtask

    task automatic test_fire();
        do_reset();
        valid = 1'b1;
        data  = 8'd255;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 2) valid = 1'b0;
            n_cmp++;
            if (membrane !== 12'(exp_mem_t[i]) || spike !== exp_spike_t[i][0] || ready !== exp_ready_t[i][0]) begin
                n_bad++;
                $display("FAIL fire_edge%0d got mem=%0d spike=%0b ready=%0b want mem=%0d spike=%0d ready=%0d",
                         i + 1, membrane, spike, ready, exp_mem_t[i], exp_spike_t[i], exp_ready_t[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if (count !== 8'd1) begin n_bad++; $display("FAIL fire_count got %0d want 1", count); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid = 1'b1;
        data  = 8'd255;
        for (int i = 0; i < 11; i++) begin
            cyc();
            n_cmp++;
            if (membrane !== 12'(exp_mem_t[i]) || spike !== exp_spike_t[i][0] || ready !== exp_ready_t[i][0]) begin
                n_bad++;
                $display("FAIL drop_edge%0d got mem=%0d spike=%0b ready=%0b want mem=%0d spike=%0d ready=%0d",
                         i + 1, membrane, spike, ready, exp_mem_t[i], exp_spike_t[i], exp_ready_t[i]);
            end
        end
        valid = 1'b0;
        n_cmp++; if (count !== 8'd2) begin n_bad++; $display("FAIL drop_count got %0d want 2", count); end
    endtask

    task automatic test_saturation();
        rst_s_n = 1'b1;
        valid_s = 1'b1;
        data_s  = 8'd200;
        cyc();
        n_cmp++;
        if (membrane_s !== 8'd200 || spike_s !== 1'b0 || ready_s !== 1'b1) begin
            n_bad++; $display("FAIL sat_first got mem=%0d spike=%0b ready=%0b want 200 0 1", membrane_s, spike_s, ready_s);
        end
        cyc();
        valid_s = 1'b0;
        n_cmp++;
        if (membrane_s !== 8'd0 || spike_s !== 1'b1 || ready_s !== 1'b0 || count_s !== 8'd1) begin
            n_bad++; $display("FAIL sat_fire got mem=%0d spike=%0b ready=%0b count=%0d want 0 1 0 1",
                              membrane_s, spike_s, ready_s, count_s);
        end
        cyc();
        n_cmp++;
        if (spike_s !== 1'b0 || ready_s !== 1'b1 || membrane_s !== 8'd0) begin
            n_bad++; $display("FAIL sat_recover got mem=%0d spike=%0b ready=%0b want 0 0 1", membrane_s, spike_s, ready_s);
        end
    endtask

    task automatic test_reset_refract();
        do_reset();
        valid = 1'b1;
        data  = 8'd255;
        repeat (3) cyc();
        valid = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL refract_pre got ready=%0b want 0", ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b1 || count !== 8'd0 || membrane !== 12'd0 || spike !== 1'b0) begin
            n_bad++; $display("FAIL refract_reset got ready=%0b count=%0d mem=%0d spike=%0b want 1 0 0 0",
                              ready, count, membrane, spike);
        end
        cyc();
        rst_n = 1'b1;
        valid = 1'b1;
        data  = 8'd100;
        cyc();
        valid = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || membrane !== 12'd100) begin
            n_bad++; $display("FAIL refract_resume got ready=%0b mem=%0d want 1 100", ready, membrane);
        end
    endtask

    task automatic test_count_wrap();
        int spikes = 0;
        int cycles = 0;
        do_reset();
        valid = 1'b1;
        data  = 8'd255;
        while (spikes < 256 && cycles < 4000) begin
            cyc();
            cycles++;
            if (spike === 1'b1) begin
                spikes++;
                n_cmp++;
                if (count !== 8'(spikes)) begin
                    n_bad++; $display("FAIL wrap_count spike%0d got %0d want %0d", spikes, count, spikes % 256);
                end
            end
        end
        valid = 1'b0;
        n_cmp++;
        if (spikes != 256) begin n_bad++; $display("FAIL wrap_timeout got %0d spikes want 256", spikes); end
        n_cmp++;
        if (count !== 8'd0) begin n_bad++; $display("FAIL wrap_final got %0d want 0", count); end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        data    = 8'd0;
        rst_s_n = 1'b0;
        valid_s = 1'b0;
        data_s  = 8'd0;
        #1;
        test_reset();
        test_leak();
        test_fire();
        test_back_to_back();
        test_saturation();
        test_reset_refract();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
